// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS subset core (FETCH/DECODE/EXEC/MEM/WB/HALT) with a
// single req/ready memory port shared between instruction and data accesses.
module mips_multicycle #(
  parameter int unsigned          WORD_SIZE = 32,
  parameter int unsigned          REG_COUNT = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic                 mem_ready,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 halted,
  output logic [WORD_SIZE-1:0] retired
);
  localparam int unsigned W  = WORD_SIZE;
  localparam int unsigned RW = $clog2(REG_COUNT);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t        state, next_state;
  logic [31:0]   ir;
  logic [W-1:0]  pc, a, b, imm, alu_out, mdr;
  logic [W-1:0]  regs [REG_COUNT];
  logic [W-1:0]  alu_c, rs_val_c, rt_val_c;
  logic [5:0]    opcode, funct;
  logic [RW-1:0] rs, rt, rd, dest;
  logic          is_r, is_addi, is_lw, is_sw, is_beq, is_j, legal, retire_c;

  // Instruction field decode from the latched IR
  assign opcode  = ir[31:26];
  assign funct   = ir[5:0];
  assign rs      = ir[21 +: RW];
  assign rt      = ir[16 +: RW];
  assign rd      = ir[11 +: RW];
  assign is_r    = (opcode == OP_RTYPE) &&
                   (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                    funct == FN_OR  || funct == FN_SLT);
  assign is_addi = (opcode == OP_ADDI);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_j    = (opcode == OP_J);
  assign legal   = is_r || is_addi || is_lw || is_sw || is_beq || is_j;
  assign dest    = is_r ? rd : rt;

  // Register 0 reads as zero without needing a reset on the array
  assign rs_val_c = (rs == '0) ? '0 : regs[rs];
  assign rt_val_c = (rt == '0) ? '0 : regs[rt];

  // An instruction completes in the cycle its last state finishes
  assign retire_c = ((state == S_EXEC) && (is_beq || is_j)) ||
                    ((state == S_MEM) && mem_ready && is_sw) ||
                    (state == S_WB);

  // ALU: R-type ops, otherwise A + imm for ADDI and load/store addressing
  always_comb begin
    alu_c = a + imm;
    if (is_r) begin
      case (funct)
        FN_SUB:  alu_c = a - b;
        FN_AND:  alu_c = a & b;
        FN_OR:   alu_c = a | b;
        FN_SLT:  alu_c = W'($signed(a) < $signed(b));
        default: alu_c = a + b;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= next_state;
  end

  // Next-state logic; FETCH and MEM stall until the memory accepts
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (mem_ready) next_state = S_DECODE;
      S_DECODE: next_state = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_lw || is_sw)       next_state = S_MEM;
        else if (is_beq || is_j)  next_state = S_FETCH;
        else                      next_state = S_WB;
      end
      S_MEM:    if (mem_ready) next_state = is_lw ? S_WB : S_FETCH;
      S_WB:     next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_FETCH;
    endcase
  end

  // Memory port driven from state; gated by reset so a pending request drops at once
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst) begin
      if (state == S_FETCH) begin
        mem_req  = 1'b1;
        mem_addr = pc;
      end else if (state == S_MEM) begin
        mem_req  = 1'b1;
        mem_we   = is_sw;
        mem_addr = alu_out;
        if (is_sw) mem_wdata = b;
      end
    end
  end

  // Datapath registers, retire counter and halt flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      imm     <= '0;
      alu_out <= '0;
      mdr     <= '0;
      retired <= '0;
      halted  <= 1'b0;
    end else begin
      halted <= (next_state == S_HALT);
      if (retire_c) retired <= retired + W'(1);
      case (state)
        S_FETCH: if (mem_ready) begin
          ir <= mem_rdata[31:0];
          pc <= pc + W'(4);
        end
        S_DECODE: begin
          a   <= rs_val_c;
          b   <= rt_val_c;
          imm <= {{(W-16){ir[15]}}, ir[15:0]};
        end
        S_EXEC: begin
          alu_out <= alu_c;
          if (is_beq && (a == b)) pc <= pc + (imm << 2);
          if (is_j)               pc <= {pc[W-1:28], ir[25:0], 2'b00};
        end
        S_MEM: if (mem_ready && is_lw) mdr <= mem_rdata;
        default: ;
      endcase
    end
  end

  // Register file write-back; register 0 is never written
  always_ff @(posedge clk) begin
    if ((state == S_WB) && (dest != '0)) regs[dest] <= is_lw ? mdr : alu_out;
  end

endmodule
